// File: rtl/dlbf_capture_slave.sv
// AXI4-Stream capture stage for the beamformer output: stores block_size*niter beats
// into a local RAM, checks TLAST/TKEEP framing and exposes a 1-cycle readback port.
module dlbf_capture_slave #(
   parameter int TDATA_WIDTH = 64,
   parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
   parameter int RAM_DEPTH   = 1536,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                   s_axis_clk,
   input  logic                   s_axis_rst,
   input  logic                   s00_axis_tvalid,
   output logic                   s00_axis_tready,
   input  logic [TDATA_WIDTH-1:0] s00_axis_tdata,
   input  logic [TKEEP_WIDTH-1:0] s00_axis_tkeep,
   input  logic                   s00_axis_tlast,
   input  logic                   go,
   input  logic [11:0]            block_size,
   input  logic [11:0]            niter,
   input  logic [ADDR_WIDTH-1:0]  rollover_addr,
   output logic                   done,
   output logic                   tlast_err,
   output logic                   keep_err,
   output logic [23:0]            beat_cnt,
   output logic [ADDR_WIDTH-1:0]  wr_addr,
   input  logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic [TDATA_WIDTH-1:0] rd_data
);

   localparam int MEM_AW = $clog2(RAM_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e                  state_q;
   logic                    go_q;
   logic                    tready_q;
   logic                    done_q;
   logic                    tlastErr_q;
   logic                    keepErr_q;
   logic [23:0]             beatCnt_q;
   logic [ADDR_WIDTH-1:0]   wrAddr_q;
   logic [ADDR_WIDTH-1:0]   wrAddr_d;
   logic [11:0]             blockSize_q;
   logic [11:0]             niter_q;
   logic [ADDR_WIDTH-1:0]   rollover_q;
   logic [11:0]             bi_q;
   logic [11:0]             it_q;
   logic [TDATA_WIDTH-1:0]  rdData_q;
   logic [TDATA_WIDTH-1:0]  mem [RAM_DEPTH];

   logic start;
   logic accept;
   logic blockEnd;
   logic runEnd;

   assign start    = go & ~go_q;
   assign accept   = s00_axis_tvalid & tready_q;
   assign blockEnd = (bi_q == blockSize_q - 12'd1);
   assign runEnd   = blockEnd && (it_q == niter_q - 12'd1);
   assign wrAddr_d = (wrAddr_q == rollover_q || wrAddr_q == LAST_ADDR) ? '0 : wrAddr_q + 1'b1;

   // Control FSM; framing is driven purely by the bi/it counters so a bad TLAST never stalls the stream.
   always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
      if (s_axis_rst) begin
         state_q     <= IDLE;
         go_q        <= 1'b0;
         tready_q    <= 1'b0;
         done_q      <= 1'b0;
         tlastErr_q  <= 1'b0;
         keepErr_q   <= 1'b0;
         beatCnt_q   <= '0;
         wrAddr_q    <= '0;
         blockSize_q <= '0;
         niter_q     <= '0;
         rollover_q  <= '0;
         bi_q        <= '0;
         it_q        <= '0;
      end else begin
         go_q <= go;
         case (state_q)
            IDLE, DONE: begin
               tready_q <= 1'b0;
               if (start) begin
                  blockSize_q <= block_size;
                  niter_q     <= niter;
                  rollover_q  <= rollover_addr;
                  done_q      <= 1'b0;
                  tlastErr_q  <= 1'b0;
                  keepErr_q   <= 1'b0;
                  beatCnt_q   <= '0;
                  wrAddr_q    <= '0;
                  bi_q        <= '0;
                  it_q        <= '0;
                  state_q     <= (block_size != '0 && niter != '0) ? RUN : DONE;
               end else if (state_q == DONE) begin
                  done_q <= 1'b1;
               end
            end
            RUN: begin
               tready_q <= 1'b1;
               if (accept) begin
                  beatCnt_q <= beatCnt_q + 24'd1;
                  wrAddr_q  <= wrAddr_d;
                  if (s00_axis_tlast != blockEnd) tlastErr_q <= 1'b1;
                  if (s00_axis_tkeep != '1)       keepErr_q  <= 1'b1;
                  if (runEnd) begin
                     state_q  <= DONE;
                     tready_q <= 1'b0;
                     done_q   <= 1'b1;
                  end else if (blockEnd) begin
                     bi_q <= '0;
                     it_q <= it_q + 12'd1;
                  end else begin
                     bi_q <= bi_q + 12'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Capture RAM is deliberately not reset so data survives a reset for post-mortem dumps.
   always_ff @(posedge s_axis_clk) begin
      if (accept) mem[wrAddr_q[MEM_AW-1:0]] <= s00_axis_tdata;
   end

   always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
      if (s_axis_rst)              rdData_q <= '0;
      else if (rd_addr <= LAST_ADDR) rdData_q <= mem[rd_addr[MEM_AW-1:0]];
      else                         rdData_q <= '0;
   end

   assign s00_axis_tready = tready_q;
   assign done            = done_q;
   assign tlast_err       = tlastErr_q;
   assign keep_err        = keepErr_q;
   assign beat_cnt        = beatCnt_q;
   assign wr_addr         = wrAddr_q;
   assign rd_data         = rdData_q;

endmodule

// File: tb/tb_dlbf_capture_slave.sv
// Self-checking bench for dlbf_capture_slave: directed runs with status checks and a
// readback scoreboard fed by read requests and drained by a separate monitor.
module tb_dlbf_capture_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic        tvalid;
   logic        tready;
   logic [63:0] tdata;
   logic [7:0]  tkeep;
   logic        tlast;
   logic        go;
   logic [11:0] blockSize;
   logic [11:0] niterIn;
   logic [15:0] rollover;
   logic        done;
   logic        tlastErr;
   logic        keepErr;
   logic [23:0] beatCnt;
   logic [15:0] wrAddr;
   logic [15:0] rdAddr;
   logic [63:0] rdData;

   int          totalCnt = 0;
   int          badCnt   = 0;
   logic [63:0] expQ[$];
   logic        rdIssue = 1'b0;
   logic        rdFire  = 1'b0;

   dlbf_capture_slave dut (
      .s_axis_clk      (clk),
      .s_axis_rst      (rst),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tready (tready),
      .s00_axis_tdata  (tdata),
      .s00_axis_tkeep  (tkeep),
      .s00_axis_tlast  (tlast),
      .go              (go),
      .block_size      (blockSize),
      .niter           (niterIn),
      .rollover_addr   (rollover),
      .done            (done),
      .tlast_err       (tlastErr),
      .keep_err        (keepErr),
      .beat_cnt        (beatCnt),
      .wr_addr         (wrAddr),
      .rd_addr         (rdAddr),
      .rd_data         (rdData)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      totalCnt++;
      if (actual !== expected) begin
         badCnt++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Readback monitor: rd_data is valid on the negedge after the edge that sampled a request.
   always @(posedge clk) rdFire <= rdIssue;

   always @(negedge clk) begin
      if (rdFire) begin
         if (expQ.size() == 0) begin
            checkOutput("readback_unexpected", rdData, 64'hDEAD);
         end else begin
            checkOutput("readback", rdData, expQ.pop_front());
         end
      end
   end

   task automatic readReq(input logic [15:0] addr, input logic [63:0] expected);
      rdAddr  = addr;
      rdIssue = 1'b1;
      expQ.push_back(expected);
      @(posedge clk);
      #1;
      rdIssue = 1'b0;
   endtask

   // Produces a clean go rising edge; returns just after the edge that acts on start.
   task automatic applyStimulus(input int bs, input int ni, input int roll);
      blockSize = 12'(bs);
      niterIn   = 12'(ni);
      rollover  = 16'(roll);
      go        = 1'b0;
      @(posedge clk);
      #1;
      go = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic sendBeats(input int n, input int bs, input int earlyIdx, input bit toggle,
                            input logic [63:0] base, input int badKeepIdx);
      int  idx = 0;
      int  cyc = 0;
      bit  rdy;
      int  lastPos;
      while (idx < n && cyc < 200) begin
         lastPos = (earlyIdx >= 0 && idx < bs) ? earlyIdx : bs - 1;
         tvalid  = toggle ? (cyc % 2 == 0) : 1'b1;
         tdata   = base + 64'(idx);
         tlast   = ((idx % bs) == lastPos);
         tkeep   = (idx == badKeepIdx) ? 8'h0F : 8'hFF;
         @(negedge clk);
         rdy = tready;
         @(posedge clk);
         if (tvalid && rdy) idx++;
         #1;
         cyc++;
      end
      tvalid = 1'b0;
      tlast  = 1'b0;
      tkeep  = 8'hFF;
      if (idx < n) checkOutput("beat_timeout", 64'(idx), 64'(n));
   endtask

   initial begin
      rst       = 1'b1;
      tvalid    = 1'b0;
      tdata     = '0;
      tkeep     = 8'hFF;
      tlast     = 1'b0;
      go        = 1'b0;
      blockSize = '0;
      niterIn   = '0;
      rollover  = '0;
      rdAddr    = '0;

      // Reset values
      #12;
      checkOutput("rst_tready", 64'(tready), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_beatcnt", 64'(beatCnt), 64'd0);
      checkOutput("rst_wraddr", 64'(wrAddr), 64'd0);
      checkOutput("rst_rddata", rdData, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Clean run: 4x2, continuous valid, data = index
      applyStimulus(4, 2, 16'hFFFF);
      sendBeats(8, 4, -1, 1'b0, 64'd0, -1);
      @(negedge clk);
      checkOutput("t1_done", 64'(done), 64'd1);
      checkOutput("t1_tready", 64'(tready), 64'd0);
      checkOutput("t1_beatcnt", 64'(beatCnt), 64'd8);
      checkOutput("t1_wraddr", 64'(wrAddr), 64'd8);
      checkOutput("t1_tlasterr", 64'(tlastErr), 64'd0);
      checkOutput("t1_keeperr", 64'(keepErr), 64'd0);
      repeat (3) @(negedge clk);
      checkOutput("t1_hold_done", 64'(done), 64'd1);
      checkOutput("t1_hold_beatcnt", 64'(beatCnt), 64'd8);
      checkOutput("t1_hold_tready", 64'(tready), 64'd0);
      #1;
      for (int i = 0; i < 8; i++) readReq(16'(i), 64'(i));

      // Toggling valid, early tlast on beat 2
      applyStimulus(4, 2, 16'hFFFF);
      sendBeats(8, 4, 2, 1'b1, 64'h100, -1);
      @(negedge clk);
      checkOutput("t2_done", 64'(done), 64'd1);
      checkOutput("t2_tlasterr", 64'(tlastErr), 64'd1);
      checkOutput("t2_keeperr", 64'(keepErr), 64'd0);
      checkOutput("t2_beatcnt", 64'(beatCnt), 64'd8);
      #1;
      for (int i = 0; i < 8; i++) readReq(16'(i), 64'h100 + 64'(i));
      readReq(16'd1536, 64'd0);

      // Rollover at 5 with an 8-beat single block, one bad keep on beat 4
      applyStimulus(8, 1, 5);
      sendBeats(8, 8, -1, 1'b0, 64'd0, 4);
      @(negedge clk);
      checkOutput("t3_wraddr", 64'(wrAddr), 64'd2);
      checkOutput("t3_keeperr", 64'(keepErr), 64'd1);
      checkOutput("t3_tlasterr", 64'(tlastErr), 64'd0);
      checkOutput("t3_done", 64'(done), 64'd1);
      #1;
      readReq(16'd0, 64'd6);
      readReq(16'd1, 64'd7);
      readReq(16'd5, 64'd5);
      readReq(16'd3, 64'd3);

      // niter = 0: straight to DONE, no beats accepted even with valid held high
      tvalid = 1'b1;
      applyStimulus(4, 0, 0);
      @(negedge clk);
      checkOutput("t4_done_cleared", 64'(done), 64'd0);
      checkOutput("t4_keeperr_cleared", 64'(keepErr), 64'd0);
      @(negedge clk);
      checkOutput("t4_done", 64'(done), 64'd1);
      checkOutput("t4_tready", 64'(tready), 64'd0);
      repeat (2) @(negedge clk);
      checkOutput("t4_beatcnt", 64'(beatCnt), 64'd0);
      #1;
      tvalid = 1'b0;

      // Reset mid-block after 3 beats, then restart
      applyStimulus(4, 2, 16'hFFFF);
      sendBeats(3, 4, -1, 1'b0, 64'h300, -1);
      @(negedge clk);
      checkOutput("t5_pre_beatcnt", 64'(beatCnt), 64'd3);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_tready", 64'(tready), 64'd0);
      checkOutput("t5_rst_beatcnt", 64'(beatCnt), 64'd0);
      checkOutput("t5_rst_wraddr", 64'(wrAddr), 64'd0);
      checkOutput("t5_rst_done", 64'(done), 64'd0);
      checkOutput("t5_rst_rddata", rdData, 64'd0);
      go = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(4, 2, 16'hFFFF);
      sendBeats(2, 4, -1, 1'b0, 64'h200, -1);
      @(negedge clk);
      checkOutput("t5_beatcnt", 64'(beatCnt), 64'd2);
      checkOutput("t5_wraddr", 64'(wrAddr), 64'd2);
      checkOutput("t5_done", 64'(done), 64'd0);
      #1;
      readReq(16'd0, 64'h200);
      readReq(16'd2, 64'h302);

      repeat (3) @(posedge clk);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
      $finish;
   end

endmodule
